piece_controller: RTL and testbench
===================================

Name: piece_controller

Overview:
- Sequencer for the active falling piece on the 8x8 Tetris board.
- Holds the four cell coordinates of the current piece and spawns pieces from a type code.
- Applies gravity, left/right moves and clockwise rotation, each checked against board bounds and the locked-cell board.
- Drives the piece renderer's coordinate/enable inputs and pulses a lock strobe so the parent can merge the piece into the board.

Parameters:
- WIDTH, 8, board columns.
- HEIGHT, 8, board rows.
- XSIZE, 3, bits per X coordinate; WIDTH <= 2**XSIZE.
- YSIZE, 3, bits per Y coordinate; HEIGHT <= 2**YSIZE.
- SPAWN_X, 3, column of pivot cell (cell 1) at spawn.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- board  input  [HEIGHT-1:0][WIDTH-1:0]  locked cells, board[y][x], y=0 top row
- spawn  input  1  request new piece (honoured in IDLE only)
- pieceType  input  3  shape at spawn: 0 I, 1 O, 2 T, 3 S, 4 Z, 5 J, 6 L, 7 treated as 0
- gravity  input  1  one-cycle pulse: move down one row
- rotate  input  1  one-cycle pulse: rotate clockwise about cell 1
- moveLeft  input  1  one-cycle pulse: X-1
- moveRight  input  1  one-cycle pulse: X+1
- pieceX  output  [3:0][XSIZE-1:0]  registered cell X coords, cells 3..0
- pieceY  output  [3:0][YSIZE-1:0]  registered cell Y coords
- pieceEn  output  1  piece visible (renderer enable)
- lockPulse  output  1  one-cycle strobe: piece landed at pieceX/pieceY
- gameOver  output  1  sticky spawn-collision flag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it takes effect at the next clk edge and overrides everything, including mid-move and LOCK.
- Reset values: state IDLE; pieceX = 0, pieceY = 0, pieceEn = 0, lockPulse = 0, gameOver = 0; type register = 0.
- States:
  - IDLE: pieceEn = 0. spawn=1 loads the shape table at column offset SPAWN_X-3, row 0.
    - Any spawn cell with board[y][x]=1 -> OVER.
    - Otherwise -> ACTIVE.
    - Outputs update at the same edge (1-cycle latency).
  - ACTIVE: pieceEn = 1. At most one action per cycle, priority gravity > rotate > moveLeft > moveRight. Lower-priority simultaneous requests are dropped, not queued.
  - LOCK: pieceEn = 1, lockPulse = 1 for exactly this cycle, coords held. Next state IDLE unconditionally.
  - OVER: gameOver = 1, pieceEn = 0. All inputs ignored until reset.
- Shape table (x,y for cells 0..3, cell 1 = pivot):
  - I (2,0)(3,0)(4,0)(5,0)
  - O (3,0)(4,0)(3,1)(4,1)
  - T (2,0)(3,0)(4,0)(3,1)
  - S (4,0)(3,0)(3,1)(2,1)
  - Z (2,0)(3,0)(3,1)(4,1)
  - J (2,0)(3,0)(4,0)(4,1)
  - L (2,0)(3,0)(4,0)(2,1)
- Candidate computation:
  - Computed combinationally from the registered coords in signed XSIZE+1 / YSIZE+1 arithmetic. No wrap: -1 and WIDTH are both out of range.
  - Rotation: x' = px - (y - py), y' = py + (x - px), where (px,py) = cell 1.
  - Type O rotation is an accepted no-op.
- Legality:
  - Legal means all four cells satisfy 0 <= x < WIDTH, 0 <= y < HEIGHT and board[y][x] = 0.
  - Legal action: coords update at the next edge.
  - Illegal move or rotate: coords unchanged, stay ACTIVE.
  - Illegal gravity (floor or stack below): -> LOCK, coords unchanged.
- Misc:
  - spawn is ignored outside IDLE.
  - board is sampled only on the evaluation cycle.
  - Board changes while ACTIVE are not rechecked against the current position.

Optional Feature:
- Macro: HARD_DROP_EN.
- Defined: adds input port hardDrop (1 bit, priority above gravity).
  - In ACTIVE, hardDrop=1 enters internal DROP state.
  - DROP applies a gravity step every cycle, ignoring all other requests, until a step is illegal, then -> LOCK.
  - pieceEn = 1 throughout DROP.
- Undefined: no hardDrop port, no DROP state; behaviour as above.

Test Plan:
- Reset, then spawn=1, pieceType=2, empty board -> next cycle pieceEn=1, X(c0..c3) = 2,3,4,3, Y = 0,0,0,1.
- T spawned, moveLeft pulsed 3 times -> min X 1, then 0, third rejected; coords unchanged, state ACTIVE.
- T spawned, empty board, 6 gravity pulses -> cell 3 at y=7. 7th pulse -> LOCK, lockPulse=1 for exactly 1 cycle, then pieceEn=0 in IDLE.
- T after one gravity ((2,1)(3,1)(4,1)(3,2)), rotate -> (3,0)(3,1)(3,2)(2,1). rotate asserted with gravity in the same cycle -> only Y+1 applied.
- board[0][3]=1, spawn type 0 -> gameOver=1, pieceEn=0. Later spawn ignored until reset; reset clears gameOver.
- HARD_DROP_EN: T spawned, board row 7 full, hardDrop=1 -> one row per cycle until cell 3 y=6, then lockPulse one cycle, then IDLE.

Source files
------------

// File: rtl/piece_controller.sv
// Active falling-piece sequencer for the 8x8 board: spawn, gravity, shifts, rotation and lock.
// Optional HARD_DROP_EN adds a hardDrop input that drops the piece until it lands.
module piece_controller #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HEIGHT  = 8,
  parameter int unsigned XSIZE   = 3,
  parameter int unsigned YSIZE   = 3,
  parameter int          SPAWN_X = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [HEIGHT-1:0][WIDTH-1:0]  board,
  input  logic                          spawn,
  input  logic [2:0]                    pieceType,
  input  logic                          gravity,
  input  logic                          rotate,
  input  logic                          moveLeft,
  input  logic                          moveRight,
`ifdef HARD_DROP_EN
  input  logic                          hardDrop,
`endif
  output logic [3:0][XSIZE-1:0]         pieceX,
  output logic [3:0][YSIZE-1:0]         pieceY,
  output logic                          pieceEn,
  output logic                          lockPulse,
  output logic                          gameOver
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StActive = 3'd1;
  localparam logic [2:0] StLock   = 3'd2;
  localparam logic [2:0] StOver   = 3'd3;
`ifdef HARD_DROP_EN
  localparam logic [2:0] StDrop   = 3'd4;
`endif

  localparam logic [2:0] TypeO = 3'd1;

  logic [2:0]            state_q, state_d;
  logic [2:0]            type_q, type_d;
  logic [3:0][XSIZE-1:0] x_q, x_d;
  logic [3:0][YSIZE-1:0] y_q, y_d;

  // Candidates carry one extra bit; a set MSB marks a negative (off-board) coordinate.
  logic [3:0][XSIZE:0] cx_cur, cx_left, cx_right, cx_rot, cx_spawn, dx;
  logic [3:0][YSIZE:0] cy_cur, cy_down, cy_rot, cy_spawn, dy;
  logic [31:0]         spawn_tbl;
  logic                ok_left, ok_right, ok_rot, ok_down, ok_spawn;

  // Packed {y3..y0, x3..x0} nibbles, pivot in cell 1, at column offset 0.
  function automatic logic [31:0] shape(input logic [2:0] t);
    case (t)
      3'd1:    return 32'h1100_4343;
      3'd2:    return 32'h1000_3432;
      3'd3:    return 32'h1100_2334;
      3'd4:    return 32'h1100_4332;
      3'd5:    return 32'h1000_4432;
      3'd6:    return 32'h1000_2432;
      default: return 32'h0000_5432;
    endcase
  endfunction

  function automatic logic fits(input logic [3:0][XSIZE:0] cx, input logic [3:0][YSIZE:0] cy,
                                input logic [HEIGHT-1:0][WIDTH-1:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cx[i][XSIZE] || cy[i][YSIZE]) begin
        ok = 1'b0;
      end else if (int'(cx[i][XSIZE-1:0]) >= int'(WIDTH) ||
                   int'(cy[i][YSIZE-1:0]) >= int'(HEIGHT)) begin
        ok = 1'b0;
      end else if (b[cy[i][YSIZE-1:0]][cx[i][XSIZE-1:0]]) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

  always_comb begin
    spawn_tbl = shape(pieceType);
    for (int i = 0; i < 4; i++) begin
      cx_cur[i]   = {1'b0, x_q[i]};
      cy_cur[i]   = {1'b0, y_q[i]};
      cx_left[i]  = cx_cur[i] - 1'b1;
      cx_right[i] = cx_cur[i] + 1'b1;
      cy_down[i]  = cy_cur[i] + 1'b1;
      dx[i]       = cx_cur[i] - cx_cur[1];
      dy[i]       = cy_cur[i] - cy_cur[1];
      cx_rot[i]   = cx_cur[1] - (XSIZE+1)'($signed(dy[i]));
      cy_rot[i]   = cy_cur[1] + (YSIZE+1)'($signed(dx[i]));
      cx_spawn[i] = (XSIZE+1)'(spawn_tbl[4*i +: 4]) + (XSIZE+1)'(SPAWN_X - 3);
      cy_spawn[i] = (YSIZE+1)'(spawn_tbl[16+4*i +: 4]);
    end
    ok_left  = fits(cx_left, cy_cur, board);
    ok_right = fits(cx_right, cy_cur, board);
    ok_rot   = fits(cx_rot, cy_rot, board);
    ok_down  = fits(cx_cur, cy_down, board);
    ok_spawn = fits(cx_spawn, cy_spawn, board);
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      StIdle: begin
        if (spawn) begin
          type_d  = (pieceType == 3'd7) ? 3'd0 : pieceType;
          state_d = ok_spawn ? StActive : StOver;
          for (int i = 0; i < 4; i++) begin
            x_d[i] = cx_spawn[i][XSIZE-1:0];
            y_d[i] = cy_spawn[i][YSIZE-1:0];
          end
        end
      end
      StActive: begin
`ifdef HARD_DROP_EN
        if (hardDrop) begin
          state_d = StDrop;
        end else
`endif
        if (gravity) begin
          if (ok_down) begin
            for (int i = 0; i < 4; i++) y_d[i] = cy_down[i][YSIZE-1:0];
          end else begin
            state_d = StLock;
          end
        end else if (rotate) begin
          // O is rotation-invariant, so its rotation is accepted without moving.
          if (type_q != TypeO && ok_rot) begin
            for (int i = 0; i < 4; i++) begin
              x_d[i] = cx_rot[i][XSIZE-1:0];
              y_d[i] = cy_rot[i][YSIZE-1:0];
            end
          end
        end else if (moveLeft) begin
          if (ok_left) begin
            for (int i = 0; i < 4; i++) x_d[i] = cx_left[i][XSIZE-1:0];
          end
        end else if (moveRight) begin
          if (ok_right) begin
            for (int i = 0; i < 4; i++) x_d[i] = cx_right[i][XSIZE-1:0];
          end
        end
      end
`ifdef HARD_DROP_EN
      StDrop: begin
        if (ok_down) begin
          for (int i = 0; i < 4; i++) y_d[i] = cy_down[i][YSIZE-1:0];
        end else begin
          state_d = StLock;
        end
      end
`endif
      StLock:  state_d = StIdle;
      StOver:  state_d = StOver;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      type_q  <= 3'd0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    pieceX    = x_q;
    pieceY    = y_q;
    lockPulse = (state_q == StLock);
    gameOver  = (state_q == StOver);
`ifdef HARD_DROP_EN
    pieceEn   = (state_q == StActive) || (state_q == StLock) || (state_q == StDrop);
`else
    pieceEn   = (state_q == StActive) || (state_q == StLock);
`endif
  end

endmodule

// File: tb/tb_piece_controller.sv
// Scoreboard bench for piece_controller: directed stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_piece_controller;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0][7:0]   board = '0;
  logic              spawn = 1'b0;
  logic [2:0]        pieceType = 3'd0;
  logic              gravity = 1'b0, rotate = 1'b0, moveLeft = 1'b0, moveRight = 1'b0;
`ifdef HARD_DROP_EN
  logic              hardDrop = 1'b0;
`endif
  logic [3:0][2:0]   pieceX, pieceY;
  logic              pieceEn, lockPulse, gameOver;

  piece_controller dut (
    .clk       (clk),
    .reset     (reset),
    .board     (board),
    .spawn     (spawn),
    .pieceType (pieceType),
    .gravity   (gravity),
    .rotate    (rotate),
    .moveLeft  (moveLeft),
    .moveRight (moveRight),
`ifdef HARD_DROP_EN
    .hardDrop  (hardDrop),
`endif
    .pieceX    (pieceX),
    .pieceY    (pieceY),
    .pieceEn   (pieceEn),
    .lockPulse (lockPulse),
    .gameOver  (gameOver)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    int          cyc;
    logic [11:0] x;
    logic [11:0] y;
    logic        en, lk, ov, cxy;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle, compare all expectations tagged for this cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      logic [11:0] gx, gy;
      e  = sb.pop_front();
      gx = pieceX;
      gy = pieceY;
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: stale entry for cycle %0d seen at %0d", e.nm, e.cyc, cyc);
      end else if ({pieceEn, lockPulse, gameOver} != {e.en, e.lk, e.ov} ||
                   (e.cxy && (gx != e.x || gy != e.y))) begin
        errors++;
        $display("FAIL %s: got en=%b lk=%b ov=%b x=%h y=%h, want en=%b lk=%b ov=%b x=%h y=%h%s",
                 e.nm, pieceEn, lockPulse, gameOver, gx, gy, e.en, e.lk, e.ov, e.x, e.y,
                 e.cxy ? "" : " (xy not checked)");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] pk(input int a, input int b, input int c, input int d);
    return {d[2:0], c[2:0], b[2:0], a[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input string nm, input logic [11:0] x, input logic [11:0] y,
                    input logic en, input logic lk, input logic ov, input logic cxy = 1'b1);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.x = x; e.y = y;
    e.en = en; e.lk = lk; e.ov = ov; e.cxy = cxy;
    sb.push_back(e);
  endtask

  task automatic act(input logic g, input logic r, input logic l, input logic rt);
    gravity = g; rotate = r; moveLeft = l; moveRight = rt;
    tick();
    gravity = 1'b0; rotate = 1'b0; moveLeft = 1'b0; moveRight = 1'b0;
  endtask

  task automatic do_spawn(input logic [2:0] t);
    spawn = 1'b1; pieceType = t;
    tick();
    spawn = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    do_reset();
    ex("reset", 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);

    do_spawn(3'd2);
    ex("spawn_t", pk(2,3,4,3), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    act(0,0,1,0); ex("left1", pk(1,2,3,2), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    act(0,0,1,0); ex("left2", pk(0,1,2,1), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    act(0,0,1,0); ex("left_wall", pk(0,1,2,1), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    act(0,0,0,1); ex("right1", pk(1,2,3,2), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    act(0,0,0,1); ex("right2", pk(2,3,4,3), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    do_spawn(3'd0); ex("spawn_in_active", pk(2,3,4,3), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    act(1,1,0,0); ex("grav_over_rot", pk(2,3,4,3), pk(1,1,1,2), 1'b1, 1'b0, 1'b0);
    act(0,1,0,0); ex("rotate_t", pk(3,3,3,2), pk(0,1,2,1), 1'b1, 1'b0, 1'b0);
    act(0,0,1,1); ex("left_over_right", pk(2,2,2,1), pk(0,1,2,1), 1'b1, 1'b0, 1'b0);
    act(0,0,0,1); ex("right_back", pk(3,3,3,2), pk(0,1,2,1), 1'b1, 1'b0, 1'b0);
    board[1][4] = 1'b1;
    act(0,1,0,0); ex("rotate_blocked", pk(3,3,3,2), pk(0,1,2,1), 1'b1, 1'b0, 1'b0);
    board[1][4] = 1'b0;
    board[3][3] = 1'b1;
    act(1,0,0,0); ex("stack_lock", pk(3,3,3,2), pk(0,1,2,1), 1'b1, 1'b1, 1'b0);
    board[3][3] = 1'b0;
    tick(); ex("lock_to_idle", pk(3,3,3,2), pk(0,1,2,1), 1'b0, 1'b0, 1'b0);

    do_spawn(3'd2);
    ex("spawn_t2", pk(2,3,4,3), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      act(1,0,0,0); ex("gravity", pk(2,3,4,3), pk(k,k,k,k+1), 1'b1, 1'b0, 1'b0);
    end
    act(1,0,0,0); ex("floor_lock", pk(2,3,4,3), pk(6,6,6,7), 1'b1, 1'b1, 1'b0);
    tick(); ex("floor_idle", pk(2,3,4,3), pk(6,6,6,7), 1'b0, 1'b0, 1'b0);
    tick(); ex("idle_hold", pk(2,3,4,3), pk(6,6,6,7), 1'b0, 1'b0, 1'b0);

    do_spawn(3'd7); ex("spawn_type7", pk(2,3,4,5), 12'h0, 1'b1, 1'b0, 1'b0);
    act(0,0,0,1); ex("i_right1", pk(3,4,5,6), 12'h0, 1'b1, 1'b0, 1'b0);
    act(0,0,0,1); ex("i_right2", pk(4,5,6,7), 12'h0, 1'b1, 1'b0, 1'b0);
    act(0,0,0,1); ex("right_wall", pk(4,5,6,7), 12'h0, 1'b1, 1'b0, 1'b0);
    act(0,1,0,0); ex("rotate_top", pk(4,5,6,7), 12'h0, 1'b1, 1'b0, 1'b0);
    do_reset(); ex("reset_active", 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);

    board[0][3] = 1'b1;
    do_spawn(3'd0); ex("game_over", 12'h0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    board = '0;
    do_spawn(3'd2); ex("over_spawn", 12'h0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    act(1,0,0,0); ex("over_grav", 12'h0, 12'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset(); ex("reset_over", 12'h0, 12'h0, 1'b0, 1'b0, 1'b0);
    do_spawn(3'd1); ex("spawn_o", pk(3,4,3,4), pk(0,0,1,1), 1'b1, 1'b0, 1'b0);
    act(0,1,0,0); ex("rotate_o", pk(3,4,3,4), pk(0,0,1,1), 1'b1, 1'b0, 1'b0);

`ifdef HARD_DROP_EN
    do_reset();
    do_spawn(3'd2); ex("drop_spawn", pk(2,3,4,3), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    board[7] = 8'hFF;
    hardDrop = 1'b1; gravity = 1'b1; moveLeft = 1'b1;
    tick();
    hardDrop = 1'b0;
    ex("drop_enter", pk(2,3,4,3), pk(0,0,0,1), 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      tick(); ex("drop_step", pk(2,3,4,3), pk(k,k,k,k+1), 1'b1, 1'b0, 1'b0);
    end
    gravity = 1'b0; moveLeft = 1'b0;
    tick(); ex("drop_lock", pk(2,3,4,3), pk(5,5,5,6), 1'b1, 1'b1, 1'b0);
    tick(); ex("drop_idle", pk(2,3,4,3), pk(5,5,5,6), 1'b0, 1'b0, 1'b0);
    board = '0;
`endif

    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
